// File: rtl/register_file_bypass.sv
// register_file_bypass: 32x32 MIPS register file with optional same-cycle write-to-read forwarding
module register_file_bypass #(
  parameter int N_BITS = 32,
  parameter logic [N_BITS-1:0] SP_RESET = 32'h7FFF_EFFC,
  parameter logic [N_BITS-1:0] GP_RESET = 32'h1000_8000,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [N_BITS-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [N_BITS-1:0] ReadData1,
  output logic [N_BITS-1:0] ReadData2
);
  logic [N_BITS-1:0] regs [31:1];
  logic fwd1, fwd2;
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++)
        regs[i] <= i == 28 ? GP_RESET : i == 29 ? SP_RESET : '0;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      regs[WriteRegister] <= WriteData;
    end
  end
  // $zero check comes first so it also masks a forwarded write to index 0
  always_comb begin
    fwd1 = BYPASS && RegWrite && WriteRegister == ReadRegister1;
    fwd2 = BYPASS && RegWrite && WriteRegister == ReadRegister2;
    ReadData1 = ReadRegister1 == 5'd0 ? '0 : fwd1 ? WriteData : regs[ReadRegister1];
    ReadData2 = ReadRegister2 == 5'd0 ? '0 : fwd2 ? WriteData : regs[ReadRegister2];
  end
endmodule

// File: tb/tb_register_file_bypass.sv
// tb_register_file_bypass: directed and random checks of bypassed and non-bypassed register files
module tb_register_file_bypass;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic we = 1'b0;
  logic [4:0] wr = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [31:0] mdl [32];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  register_file_bypass #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(rst_n), .RegWrite(we), .WriteRegister(wr), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1_b), .ReadData2(rd2_b)
  );
  register_file_bypass #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(rst_n), .RegWrite(we), .WriteRegister(wr), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1_n), .ReadData2(rd2_n)
  );
  function automatic logic [31:0] model_read(bit byp, logic [4:0] ra);
    if (ra == 0) return '0;
    if (byp && we && wr == ra) return wd;
    return mdl[ra];
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_model(string tag);
    #1;
    check({tag, "_b1"}, rd1_b, model_read(1'b1, ra1));
    check({tag, "_b2"}, rd2_b, model_read(1'b1, ra2));
    check({tag, "_n1"}, rd1_n, model_read(1'b0, ra1));
    check({tag, "_n2"}, rd2_n, model_read(1'b0, ra2));
  endtask
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      foreach (mdl[i]) mdl[i] = '0;
      mdl[28] = GP;
      mdl[29] = SP;
    end else if (we && wr != 0) mdl[wr] = wd;
    @(negedge clk);
  endtask
  initial begin
    foreach (mdl[i]) mdl[i] = 'x;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    ra1 = 5'd0; ra2 = 5'd5;
    check_model("rst_0_5");
    check("rst_r0", rd1_b, 32'h0);
    check("rst_r5", rd2_n, 32'h0);
    ra1 = 5'd28; ra2 = 5'd29;
    #1;
    check("rst_gp", rd1_b, 32'h1000_8000);
    check("rst_sp", rd2_n, 32'h7FFF_EFFC);
    we = 1'b1; wr = 5'd8; wd = 32'hDEAD_BEEF;
    cycle();
    wr = 5'd31; wd = 32'h0000_0011;
    cycle();
    we = 1'b0; ra1 = 5'd8; ra2 = 5'd31;
    #1;
    check("wr_r8", rd1_n, 32'hDEAD_BEEF);
    check("wr_r31", rd2_b, 32'h0000_0011);
    we = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check("zero_byp", rd1_b, 32'h0);
    check("zero_byp2", rd2_b, 32'h0);
    cycle();
    we = 1'b0;
    #1;
    check("zero_after", rd1_b, 32'h0);
    we = 1'b1; wr = 5'd9; wd = 32'h1;
    cycle();
    wd = 32'h55; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    check("byp_b1", rd1_b, 32'h55);
    check("byp_b2", rd2_b, 32'h55);
    check("byp_n1", rd1_n, 32'h1);
    check("byp_n2", rd2_n, 32'h1);
    cycle();
    we = 1'b0;
    #1;
    check("byp_after_b", rd1_b, 32'h55);
    check("byp_after_n", rd2_n, 32'h55);
    wr = 5'd8; wd = 32'h1234; ra1 = 5'd8;
    cycle();
    #1;
    check("wdis_b", rd1_b, 32'hDEAD_BEEF);
    check("wdis_n", rd1_n, 32'hDEAD_BEEF);
    rst_n = 1'b0; we = 1'b1; wr = 5'd10; wd = 32'hAAAA; ra1 = 5'd10; ra2 = 5'd29;
    #1;
    check("rstw_byp", rd1_b, 32'hAAAA);
    check("rstw_nobyp", rd1_n, 32'h0);
    cycle();
    rst_n = 1'b1; we = 1'b0;
    #1;
    check("rstw_r10", rd1_b, 32'h0);
    check("rstw_sp", rd2_n, SP);
    ra1 = 5'd8; ra2 = 5'd31;
    #1;
    check("rstw_r8", rd1_n, 32'h0);
    check("rstw_r31", rd2_b, 32'h0);
    for (int n = 0; n < 400; n++) begin
      rst_n = $urandom_range(0, 49) != 0;
      we = $urandom_range(0, 2) != 0;
      wr = 5'($urandom);
      wd = $urandom;
      ra1 = $urandom_range(0, 2) == 0 ? wr : 5'($urandom);
      ra2 = $urandom_range(0, 3) == 0 ? wr : 5'($urandom);
      check_model("rand");
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
